// File: rtl/sad_pkg.sv
// Shared types and helpers for the SAD minimum-select datapath.
package sad_pkg;

    localparam int SAD_W_DEF = 12;

    // Sideband carried alongside each tree level.
    typedef struct packed {
        logic valid;
        logic last;
        logic ovf;
    } sad_tag_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Linear index to motion vector for a power-of-two grid width.
    function automatic int mv_x(input int idx, input int grid_w);
        return idx & (grid_w - 1);
    endfunction

    function automatic int mv_y(input int idx, input int grid_w);
        return idx >> clog2(grid_w);
    endfunction

endpackage

// File: rtl/sad_min2.sv
// Combinational pairwise SAD minimum; a must be the lower-index side so ties keep a.
module sad_min2 #(
    parameter int SAD_W = 12,
    parameter int IDX_W = 4
) (
    input  logic [SAD_W-1:0] a_sad,
    input  logic [IDX_W-1:0] a_idx,
    input  logic [SAD_W-1:0] b_sad,
    input  logic [IDX_W-1:0] b_idx,
    output logic [SAD_W-1:0] min_sad,
    output logic [IDX_W-1:0] min_idx
);

    always_comb begin
        min_sad = a_sad;
        min_idx = a_idx;
        if (a_sad > b_sad) begin
            min_sad = b_sad;
            min_idx = b_idx;
        end
    end

endmodule

// File: rtl/sad_min_select.sv
// Registered SAD comparator tree folded into a per-window running minimum,
// emitting best SAD, linear index and motion vector on a valid/ready port.
module sad_min_select
    import sad_pkg::*;
#(
    parameter int SAD_W     = SAD_W_DEF,
    parameter int NUM_CAND  = 16,
    parameter int GRID_W    = 4,
    parameter int MAX_BEATS = 4,
    parameter int IDX_W     = clog2(NUM_CAND * MAX_BEATS),
    parameter int MV_W_X    = clog2(GRID_W),
    parameter int MV_W_Y    = IDX_W - MV_W_X
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [NUM_CAND*SAD_W-1:0] in_sad,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SAD_W-1:0]          out_sad,
    output logic [IDX_W-1:0]          out_idx,
    output logic [MV_W_X-1:0]         out_mv_x,
    output logic [MV_W_Y-1:0]         out_mv_y,
    output logic                      out_ovf
);

    localparam int LVL    = clog2(NUM_CAND);
    localparam int NODES  = NUM_CAND - 1;
    localparam int BEAT_W = (MAX_BEATS > 1) ? clog2(MAX_BEATS) : 1;
    localparam int CNT_W  = clog2(MAX_BEATS + 1);

    logic adv;
    logic accept;
    logic out_valid_reg;

    assign adv       = !out_valid_reg || out_ready;
    assign in_ready  = rst && adv;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_reg;

    // Beat counter saturates at MAX_BEATS; that value marks an overflow beat.
    logic [CNT_W-1:0]  cnt_reg;
    logic              beat_ovf;
    logic [BEAT_W-1:0] beat_num;

    assign beat_ovf = (cnt_reg == CNT_W'(MAX_BEATS));
    assign beat_num = BEAT_W'(cnt_reg);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (accept) begin
            if (in_last) begin
                cnt_reg <= '0;
            end else if (!beat_ovf) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    logic [SAD_W-1:0] leaf_sad [NUM_CAND];
    logic [LVL-1:0]   leaf_idx [NUM_CAND];

    generate
        for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_leaf
            assign leaf_sad[gi] = in_sad[gi*SAD_W +: SAD_W];
            assign leaf_idx[gi] = LVL'(gi);
        end
    endgenerate

    // Heap-ordered tree: node i has children 2i+1 / 2i+2, indices >= NODES are lanes.
    logic [SAD_W-1:0] min_sad      [NODES];
    logic [LVL-1:0]   min_idx      [NODES];
    logic [SAD_W-1:0] node_sad_reg [NODES];
    logic [LVL-1:0]   node_idx_reg [NODES];

    generate
        for (genvar gi = 0; gi < NODES; gi++) begin : g_node
            localparam int CA = 2 * gi + 1;
            logic [SAD_W-1:0] a_sad;
            logic [SAD_W-1:0] b_sad;
            logic [LVL-1:0]   a_idx;
            logic [LVL-1:0]   b_idx;

            if (CA >= NODES) begin : g_from_leaf
                assign a_sad = leaf_sad[CA-NODES];
                assign a_idx = leaf_idx[CA-NODES];
                assign b_sad = leaf_sad[CA-NODES+1];
                assign b_idx = leaf_idx[CA-NODES+1];
            end else begin : g_from_node
                assign a_sad = node_sad_reg[CA];
                assign a_idx = node_idx_reg[CA];
                assign b_sad = node_sad_reg[CA+1];
                assign b_idx = node_idx_reg[CA+1];
            end

            sad_min2 #(
                .SAD_W (SAD_W),
                .IDX_W (LVL)
            ) u_min2 (
                .a_sad   (a_sad),
                .a_idx   (a_idx),
                .b_sad   (b_sad),
                .b_idx   (b_idx),
                .min_sad (min_sad[gi]),
                .min_idx (min_idx[gi])
            );
        end
    endgenerate

    sad_tag_t          tag_reg  [LVL];
    logic [BEAT_W-1:0] beat_reg [LVL];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NODES; i++) begin
                node_sad_reg[i] <= '0;
                node_idx_reg[i] <= '0;
            end
            for (int k = 0; k < LVL; k++) begin
                tag_reg[k]  <= '0;
                beat_reg[k] <= '0;
            end
        end else if (adv) begin
            for (int i = 0; i < NODES; i++) begin
                node_sad_reg[i] <= min_sad[i];
                node_idx_reg[i] <= min_idx[i];
            end
            tag_reg[0]  <= '{valid: accept, last: in_last, ovf: beat_ovf};
            beat_reg[0] <= beat_num;
            for (int k = 1; k < LVL; k++) begin
                tag_reg[k]  <= tag_reg[k-1];
                beat_reg[k] <= beat_reg[k-1];
            end
        end
    end

    sad_tag_t         tree_tag;
    logic [SAD_W-1:0] tree_sad;
    logic [IDX_W-1:0] tree_idx;

    assign tree_tag = tag_reg[LVL-1];
    assign tree_sad = node_sad_reg[0];
    assign tree_idx = IDX_W'({beat_reg[LVL-1], node_idx_reg[0]});

    logic             acc_active_reg;
    logic [SAD_W-1:0] acc_sad_reg;
    logic [IDX_W-1:0] acc_idx_reg;
    logic             acc_ovf_reg;
    logic             first_beat;
    logic             take;
    logic [SAD_W-1:0] fold_sad;
    logic [IDX_W-1:0] fold_idx;
    logic             fold_ovf;

    // Earlier beats win ties; overflow beats only raise the sticky flag.
    always_comb begin
        first_beat = !acc_active_reg;
        take       = !tree_tag.ovf && (first_beat || (tree_sad < acc_sad_reg));
        fold_sad   = take ? tree_sad : acc_sad_reg;
        fold_idx   = take ? tree_idx : acc_idx_reg;
        fold_ovf   = tree_tag.ovf || (!first_beat && acc_ovf_reg);
    end

    logic [SAD_W-1:0] out_sad_reg;
    logic [IDX_W-1:0] out_idx_reg;
    logic             out_ovf_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_active_reg <= 1'b0;
            acc_sad_reg    <= '0;
            acc_idx_reg    <= '0;
            acc_ovf_reg    <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_sad_reg    <= '0;
            out_idx_reg    <= '0;
            out_ovf_reg    <= 1'b0;
        end else if (adv) begin
            out_valid_reg <= tree_tag.valid && tree_tag.last;
            if (tree_tag.valid) begin
                if (tree_tag.last) begin
                    out_sad_reg    <= fold_sad;
                    out_idx_reg    <= fold_idx;
                    out_ovf_reg    <= fold_ovf;
                    acc_active_reg <= 1'b0;
                end else begin
                    acc_sad_reg    <= fold_sad;
                    acc_idx_reg    <= fold_idx;
                    acc_ovf_reg    <= fold_ovf;
                    acc_active_reg <= 1'b1;
                end
            end
        end
    end

    assign out_sad  = out_sad_reg;
    assign out_idx  = out_idx_reg;
    assign out_ovf  = out_ovf_reg;
    assign out_mv_x = MV_W_X'(mv_x(int'(out_idx_reg), GRID_W));
    assign out_mv_y = MV_W_Y'(mv_y(int'(out_idx_reg), GRID_W));

endmodule

// File: tb/tb_sad_min_select.sv
// Self-checking bench for sad_min_select: directed scenarios plus random windows
// against a flat "first strictly-smallest in linear order" reference model.
module tb_sad_min_select;

    localparam int SAD_W     = 12;
    localparam int NUM_CAND  = 16;
    localparam int GRID_W    = 4;
    localparam int MAX_BEATS = 4;
    localparam int IDX_W     = 6;
    localparam int MV_W_X    = 2;
    localparam int MV_W_Y    = 4;

    typedef logic [NUM_CAND*SAD_W-1:0] beat_t;
    typedef struct packed {
        logic [SAD_W-1:0]  sad;
        logic [IDX_W-1:0]  idx;
        logic [MV_W_X-1:0] mvx;
        logic [MV_W_Y-1:0] mvy;
        logic              ovf;
    } res_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    beat_t             in_sad;
    logic              out_valid;
    logic              out_ready;
    logic [SAD_W-1:0]  out_sad;
    logic [IDX_W-1:0]  out_idx;
    logic [MV_W_X-1:0] out_mv_x;
    logic [MV_W_Y-1:0] out_mv_y;
    logic              out_ovf;

    int   checks   = 0;
    int   failures = 0;
    bit   bp_on    = 1'b0;
    res_t got_q[$];
    res_t exp_q[$];

    sad_min_select #(
        .SAD_W     (SAD_W),
        .NUM_CAND  (NUM_CAND),
        .GRID_W    (GRID_W),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_sad    (in_sad),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sad   (out_sad),
        .out_idx   (out_idx),
        .out_mv_x  (out_mv_x),
        .out_mv_y  (out_mv_y),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    // A result is taken at the posedge following a negedge that sees valid && ready.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1)
            got_q.push_back({out_sad, out_idx, out_mv_x, out_mv_y, out_ovf});
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout need=finish");
        $fatal(1, "watchdog");
    end

    function automatic string fmt(input res_t r);
        return $sformatf("sad=%03h idx=%0d mv=(%0d,%0d) ovf=%0b", r.sad, r.idx, r.mvx, r.mvy, r.ovf);
    endfunction

    function automatic beat_t make_beat(input logic [SAD_W-1:0] fill, input int lane,
                                        input logic [SAD_W-1:0] val);
        beat_t b;
        for (int l = 0; l < NUM_CAND; l++) b[l*SAD_W +: SAD_W] = (l == lane) ? val : fill;
        return b;
    endfunction

    function automatic beat_t rand_beat(input int lo, input int hi);
        beat_t b;
        for (int l = 0; l < NUM_CAND; l++) b[l*SAD_W +: SAD_W] = SAD_W'($urandom_range(hi, lo));
        return b;
    endfunction

    // Reference: scan the in-range beats in linear order, keep the first strict minimum.
    function automatic res_t model_window(input beat_t beats[$]);
        res_t  r;
        beat_t b;
        int    best;
        int    best_idx;
        int    v;
        best = -1;
        best_idx = 0;
        for (int bi = 0; bi < beats.size() && bi < MAX_BEATS; bi++) begin
            b = beats[bi];
            for (int l = 0; l < NUM_CAND; l++) begin
                v = int'(b[l*SAD_W +: SAD_W]);
                if (best < 0 || v < best) begin
                    best = v;
                    best_idx = bi * NUM_CAND + l;
                end
            end
        end
        r.sad = SAD_W'(best);
        r.idx = IDX_W'(best_idx);
        r.mvx = MV_W_X'(best_idx % GRID_W);
        r.mvy = MV_W_Y'(best_idx / GRID_W);
        r.ovf = (beats.size() > MAX_BEATS);
        return r;
    endfunction

    // Called and returns at posedge+1.
    task automatic send_beat(input beat_t data, input logic last);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_sad   = data;
        in_last  = last;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout got=%b need=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_window(input beat_t beats[$]);
        for (int i = 0; i < beats.size(); i++) send_beat(beats[i], i == beats.size() - 1);
    endtask

    task automatic wait_results(input int n, input string name);
        int waited;
        waited = 0;
        while (got_q.size() < n && waited < 500) begin
            @(posedge clk); #1;
            waited++;
        end
        if (got_q.size() < n) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout got=%0d results need=%0d", name, got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_sad = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b need=0", out_valid); end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b need=0", in_ready); end
        checks++;
        if ({out_sad, out_idx} !== '0) begin failures++; $display("FAIL reset_data got=%h/%0d need=0/0", out_sad, out_idx); end
        checks++;
        if ({out_mv_x, out_mv_y, out_ovf} !== '0) begin
            failures++;
            $display("FAIL reset_mv_ovf got=(%0d,%0d) ovf=%b need=(0,0) ovf=0", out_mv_x, out_mv_y, out_ovf);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b need=1", in_ready); end
        @(posedge clk); #1;
        $display("reset done");
    endtask

    task automatic test_single_beat();
        int lat;
        lat = 0;
        send_beat(make_beat(12'h0FF, 5, 12'h010), 1'b1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (lat != 5) begin failures++; $display("FAIL single_latency got=%0d need=5", lat); end
        exp_q.push_back({12'h010, 6'd5, 2'd1, 4'd1, 1'b0});
        wait_results(1, "single_beat");
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            res_t e;
            res_t g;
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL single_beat got %s need %s", fmt(g), fmt(e)); end
            else $display("single_beat %s", fmt(g));
        end
        exp_q.delete();
    endtask

    task automatic test_multi_beat();
        beat_t w[$];
        beat_t b;
        for (int i = 0; i < 4; i++) begin
            b = rand_beat(4, 4095);
            if (i == 2) b[14*SAD_W +: SAD_W] = 12'h003;
            w.push_back(b);
        end
        send_window(w);
        exp_q.push_back({12'h003, 6'd46, 2'd2, 4'd11, 1'b0});
        wait_results(1, "multi_beat");
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            res_t e;
            res_t g;
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL multi_beat got %s need %s", fmt(g), fmt(e)); end
            else $display("multi_beat %s", fmt(g));
        end
        exp_q.delete();
    endtask

    task automatic test_ties();
        beat_t w[$];
        w = {make_beat(12'h7FF, -1, 12'h0), make_beat(12'h7FF, -1, 12'h0)};
        send_window(w);
        exp_q.push_back({12'h7FF, 6'd0, 2'd0, 4'd0, 1'b0});
        w = {make_beat(12'h001, 3, 12'h001)};
        w[0][9*SAD_W +: SAD_W] = 12'h001;
        for (int l = 0; l < NUM_CAND; l++)
            if (l != 3 && l != 9) w[0][l*SAD_W +: SAD_W] = 12'h800;
        send_window(w);
        exp_q.push_back({12'h001, 6'd3, 2'd3, 4'd0, 1'b0});
        w = {make_beat(12'hFFF, 7, 12'h005), make_beat(12'hFFF, 2, 12'h005)};
        send_window(w);
        exp_q.push_back({12'h005, 6'd7, 2'd3, 4'd1, 1'b0});
        w = {make_beat(12'hFFF, -1, 12'h0)};
        send_window(w);
        exp_q.push_back({12'hFFF, 6'd0, 2'd0, 4'd0, 1'b0});
        w = {make_beat(12'h0FF, -1, 12'h0), make_beat(12'h0FF, -1, 12'h0),
             make_beat(12'h0FF, -1, 12'h0), make_beat(12'h0FF, 15, 12'h000)};
        send_window(w);
        exp_q.push_back({12'h000, 6'd63, 2'd3, 4'd15, 1'b0});
        wait_results(5, "ties");
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            res_t e;
            res_t g;
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL ties got %s need %s", fmt(g), fmt(e)); end
            else $display("ties %s", fmt(g));
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        beat_t w[$];
        out_ready = 1'b0;
        w = {make_beat(12'h200, 10, 12'h011)};
        send_window(w);
        exp_q.push_back({12'h011, 6'd10, 2'd2, 4'd2, 1'b0});
        w = {make_beat(12'h300, -1, 12'h0), make_beat(12'h300, 1, 12'h022)};
        send_window(w);
        exp_q.push_back({12'h022, 6'd17, 2'd1, 4'd4, 1'b0});
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
        end
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b need=0", in_ready); end
            checks++;
            if (out_valid !== 1'b1 || out_sad !== 12'h011) begin
                failures++;
                $display("FAIL bp_hold got valid=%b sad=%03h need valid=1 sad=011", out_valid, out_sad);
            end
        end
        checks++;
        if (got_q.size() != 0) begin failures++; $display("FAIL bp_no_take got=%0d results need=0", got_q.size()); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        w = {make_beat(12'h400, 0, 12'h033)};
        send_window(w);
        exp_q.push_back({12'h033, 6'd0, 2'd0, 4'd0, 1'b0});
        wait_results(3, "backpressure");
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != 3) begin failures++; $display("FAIL bp_count got=%0d results need=3", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            res_t e;
            res_t g;
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL backpressure got %s need %s", fmt(g), fmt(e)); end
            else $display("backpressure %s", fmt(g));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_overflow();
        beat_t w[$];
        beat_t b;
        for (int i = 0; i < 5; i++) begin
            b = rand_beat(12'h100, 4095);
            if (i == 1) b[6*SAD_W +: SAD_W] = 12'h050;
            if (i == 4) b[0 +: SAD_W] = 12'h000;
            w.push_back(b);
        end
        send_window(w);
        exp_q.push_back({12'h050, 6'd22, 2'd2, 4'd5, 1'b0 | 1'b1});
        w = {make_beat(12'h0F0, 8, 12'h0E0)};
        send_window(w);
        exp_q.push_back({12'h0E0, 6'd8, 2'd0, 4'd2, 1'b0});
        wait_results(2, "overflow");
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            res_t e;
            res_t g;
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL overflow got %s need %s", fmt(g), fmt(e)); end
            else $display("overflow %s", fmt(g));
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_window();
        out_ready = 1'b0;
        send_beat(make_beat(12'h100, 4, 12'h010), 1'b1);
        send_beat(rand_beat(0, 4095), 1'b0);
        send_beat(rand_beat(0, 4095), 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_ctrl got valid=%b ready=%b need 0 0", out_valid, in_ready);
        end
        checks++;
        if ({out_sad, out_idx, out_mv_x, out_mv_y, out_ovf} !== '0) begin
            failures++;
            $display("FAIL midrst_data got sad=%03h idx=%0d need sad=000 idx=0", out_sad, out_idx);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != 0) begin failures++; $display("FAIL midrst_stale got=%0d results need=0", got_q.size()); end
        got_q.delete();
        send_beat(make_beat(12'h123, 12, 12'h0AB), 1'b1);
        exp_q.push_back({12'h0AB, 6'd12, 2'd0, 4'd3, 1'b0});
        wait_results(1, "reset_mid_window");
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            res_t e;
            res_t g;
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL reset_mid_window got %s need %s", fmt(g), fmt(e)); end
            else $display("reset_mid_window %s", fmt(g));
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        int nwin;
        nwin = 25;
        bp_on = 1'b1;
        fork
            while (bp_on) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(3, 0) != 0);
            end
        join_none
        for (int n = 0; n < nwin; n++) begin
            beat_t w[$];
            int    nb;
            bit    narrow;
            nb = $urandom_range(6, 1);
            narrow = 1'($urandom_range(1, 0));
            for (int i = 0; i < nb; i++) w.push_back(narrow ? rand_beat(0, 7) : rand_beat(0, 4095));
            send_window(w);
            exp_q.push_back(model_window(w));
        end
        wait_results(nwin, "random");
        bp_on = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            res_t e;
            res_t g;
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL random got %s need %s", fmt(g), fmt(e)); end
            else $display("random %s", fmt(g));
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_ties();
        test_backpressure();
        test_overflow();
        test_reset_mid_window();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sad_min_select.md
Name: sad_min_select

Overview:
- Parametrised successor to the 16-way SAD minimum comparator in the full-search block-matching datapath.
- Accepts NUM_CAND SAD values per beat and reduces them through a registered comparator tree.
- Folds a running minimum across a multi-beat search window and emits the winning SAD, its linear index and the (dx,dy) motion vector on a valid/ready output.
- Sits between the SAD accumulator array and the motion-vector writeback.

Parameters:
- SAD_W, 12, width of one SAD value.
- NUM_CAND, 16, candidates per beat; power of two, at least 2.
- GRID_W, 4, candidates per search-grid row; power of two.
- MAX_BEATS, 4, beats per window before overflow; at least 1.
- IDX_W, clog2(NUM_CAND*MAX_BEATS), width of the linear index (derived).
- MV_W, clog2(GRID_W) for dx; for dy it is IDX_W minus that (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  beat of candidates present.
- in_ready  out  1  block can accept a beat this cycle.
- in_last  in  1  beat closes the search window.
- in_sad  in  NUM_CAND*SAD_W  lane k occupies bits [k*SAD_W +: SAD_W].
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes the result.
- out_sad  out  SAD_W  minimum SAD.
- out_idx  out  IDX_W  linear index, beat*NUM_CAND+lane.
- out_mv_x  out  MV_W_X  out_idx mod GRID_W.
- out_mv_y  out  MV_W_Y  out_idx / GRID_W.
- out_ovf  out  1  window exceeded MAX_BEATS.

Behaviour:
- Reset (rst==0 at posedge):
  - Clears all pipeline valids, the accumulator, the beat counter and all outputs.
  - out_valid, out_ovf and all data outputs go to 0.
  - A partial window is discarded. in_ready is 0 during reset.
- Global advance: adv = !out_valid || out_ready; in_ready = adv.
  - When adv==0, every pipeline register holds, including valids.
- Beat accept:
  - A beat is taken on in_valid && in_ready.
  - Stage 0 tags each lane with a local index 0..NUM_CAND-1.
- Tree:
  - clog2(NUM_CAND) registered stages, each a pairwise min.
  - Tie rule: the lower index wins. Replace only on strictly-less (a > b picks b).
  - Each stage carries valid, last, sad, local index and the beat number.
- Beat number:
  - The counter increments per accepted beat and resets to 0 after an accepted in_last.
  - If the count would reach MAX_BEATS, the beat is flagged ovf. Its SAD does not participate, and the counter saturates.
- Accumulator (1 stage after the tree):
  - On the first beat of a window, load the tree result.
  - Otherwise replace only if the tree SAD is strictly less than the accumulator SAD, so an earlier beat wins ties.
  - Combined index = beat*NUM_CAND + local index.
  - The ovf flag is ORed into a sticky window flag.
- Output: when the last-tagged beat leaves the accumulator stage:
  - out_sad, out_idx and out_ovf load the final combined result. The compare with that beat is included in the same cycle.
  - out_valid is set.
  - The accumulator re-arms for a new window.
- Output hold: out_valid stays 1 with stable data until out_valid && out_ready.
  - A new result may load in the same cycle as the handshake (back-to-back windows).
- MV: out_mv_x = out_idx[MV_W_X-1:0]; out_mv_y = out_idx[IDX_W-1:MV_W_X]. This is pure bit slicing, valid with out_valid.
- Latency:
  - An in_last beat accepted at cycle t gives out_valid at t+clog2(NUM_CAND)+1, absent stalls.
  - Throughput is 1 beat per cycle.
- Single-beat window (in_last on the first beat) is legal: the result is that beat alone.
- Equal SADs everywhere give idx 0, mv (0,0).
- SAD values are unsigned, and full range 0..2^SAD_W-1 is legal.

Decomposition:
- Shared package sad_pkg:
  - SAD_W default.
  - A clog2 function.
  - The MV packing helper: linear index to (dx,dy) for a GRID_W.
  - A struct or typedef {sad, idx, valid, last, ovf} for a pipeline entry.
- One natural sub-module, sad_min2:
  - Combinational pairwise min with the lower-index tie rule.
  - Instantiated NUM_CAND-1 times in the generate tree; registers live in the parent.

Test Plan:
- Defaults, one beat with in_last, lane 5 = 0x010, others 0x0FF -> after 5 cycles out_sad=0x010, idx=5, mv=(1,1), ovf=0.
- Four beats, minimum 0x003 at beat 2 lane 14, in_last on beat 3 -> idx=46, mv_x=2, mv_y=11, out_sad=0x003.
- Ties: all lanes 0x7FF in beats 0 and 1 -> idx=0. Lanes 3 and 9 both 0x001 -> idx=3.
- Backpressure:
  - Hold out_ready=0 with a result valid -> in_ready=0 and the tree holds.
  - Raise out_ready -> next window result follows with no beat lost or duplicated.
- Overflow: five beats before in_last with MAX_BEATS=4, beat 4 lane 0 = 0x000 -> ignored, out_ovf=1, minimum from beats 0-3.
- Reset mid-window: rst=0 after 2 beats -> all outputs 0. A following single-beat window returns only its own minimum.
